// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter.
//  - tx_state_e   : transmitter FSM state encoding (also exported on dbg_state)
//  - CMD_* / RESP_*: common keyboard command and response bytes
//  - us_to_cycles : converts a microsecond interval to clock cycles at a given clock rate
//  - max3         : largest of three cycle constants, used to size counters
//  - frame_bits   : {odd parity, data} as shifted out LSB-first
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_WAIT_CLK  = 3'd3,
      ST_SHIFT     = 3'd4,
      ST_ACK       = 3'd5,
      ST_WAIT_IDLE = 3'd6,
      ST_ABORT     = 3'd7
   } tx_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RESP_ACK     = 8'hFA;
   localparam logic [7:0] RESP_RESEND  = 8'hFE;

   // 64-bit intermediate: 15000 us * 50 MHz does not fit in 32 bits.
   function automatic int unsigned us_to_cycles(input int unsigned us,
                                                input int unsigned freq_hz);
      logic [63:0] prod;
      prod = 64'(us) * 64'(freq_hz) / 64'd1_000_000;
      return prod[31:0];
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic [8:0] frame_bits(input logic [7:0] d);
      return {~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- 2-FF synchronizer for the PS2_CLK / PS2_DAT pins plus a
// falling-edge detector on the synchronized clock. Shared with the receiver.
// Ports:
//  clk, reset_n  system clock, asynchronous active-low reset
//  ps2_clk_in    raw PS2_CLK pin level (asynchronous)
//  ps2_data_in   raw PS2_DAT pin level (asynchronous)
//  clk_s         synchronized PS2_CLK
//  data_s        synchronized PS2_DAT
//  clk_fall      1-cycle pulse when clk_s goes 1 -> 0
// The synchronizer resets to 0, so the lines read as busy until two clocks
// after reset release; clk_prev also resets to 0 so no false fall appears.
module ps2_line_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic [1:0] clk_meta;
   logic [1:0] data_meta;
   logic       clk_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta  <= 2'b00;
         data_meta <= 2'b00;
         clk_prev  <= 1'b0;
      end else begin
         clk_meta  <= {clk_meta[0], ps2_clk_in};
         data_meta <= {data_meta[0], ps2_data_in};
         clk_prev  <= clk_meta[1];
      end
   end

   assign clk_s    = clk_meta[1];
   assign data_s   = data_meta[1];
   assign clk_fall = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter. Sends one command byte to the
// keyboard over the open-drain PS2_CLK/PS2_DAT lines: clock inhibit,
// request-to-send, bit shifting on device falling edges, acknowledge check.
// Ports:
//  clk, reset_n           system clock, asynchronous active-low reset
//  tx_valid/tx_data       command request and byte
//  tx_ready               block can accept a command (idle and both lines high)
//  ps2_clk_in/ps2_data_in raw pin levels
//  ps2_clk_oe/ps2_data_oe 1 = pull the line low, 0 = release
//  busy                   transmission in progress; receiver drops line activity
//  tx_done                1-cycle pulse: byte sent and acknowledged
//  tx_ack_err             1-cycle pulse: device did not acknowledge at fall 11
//  tx_timeout             1-cycle pulse: start or frame timeout
//  dbg_state              current FSM state
// Handshake: a command is accepted on a clock edge where tx_valid & tx_ready;
// tx_data is captured on that edge. tx_valid while tx_ready=0 is ignored and
// is not queued.
// Configuration macro: PS2_TX_RETRY_EN -- when defined, a failed attempt is
// retried with the same byte up to MAX_RETRY times before the error pulses.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned INHIBIT_US  = 100,
   parameter int unsigned START_TO_US = 15000,
   parameter int unsigned FRAME_TO_US = 2000,
   parameter int unsigned MAX_RETRY   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_ack_err,
   output logic       tx_timeout,
   output tx_state_e  dbg_state
);

   localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
   localparam int unsigned START_CYC   = us_to_cycles(START_TO_US, CLK_FREQ_HZ);
   localparam int unsigned FRAME_CYC   = us_to_cycles(FRAME_TO_US, CLK_FREQ_HZ);
   localparam int unsigned CNT_LIMIT   = max3(INHIBIT_CYC, START_CYC, FRAME_CYC);
   localparam int          CW          = $clog2(CNT_LIMIT + 1);
   localparam int          RW          = $clog2(MAX_RETRY + 2);
   localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_LIMIT);

`ifdef PS2_TX_RETRY_EN
   localparam int unsigned RETRIES = MAX_RETRY;
`else
   localparam int unsigned RETRIES = 0;
`endif

   tx_state_e      state;
   logic [CW-1:0]  cnt;        // inhibit length, then start timeout
   logic [CW-1:0]  fto_cnt;    // frame timeout from first fall
   logic [3:0]     bit_cnt;    // device falls seen in this frame
   logic [8:0]     shreg;      // remaining {parity, data} bits, LSB next
   logic [7:0]     data_q;     // held for retries
   logic [RW-1:0]  retry_cnt;
   logic           abort_to;   // reason for ABORT: 1 = timeout, 0 = no ack
   logic           clk_s, data_s, clk_fall;
   logic           accept;

   ps2_line_sync u_sync (
      .clk         (clk),
      .reset_n     (reset_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_s       (clk_s),
      .data_s      (data_s),
      .clk_fall    (clk_fall)
   );

   assign tx_ready  = (state == ST_IDLE) & clk_s & data_s;
   assign accept    = tx_valid & tx_ready;
   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

   // Counters stop at their limit instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         fto_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         data_q      <= '0;
         retry_cnt   <= '0;
         abort_to    <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_ack_err  <= 1'b0;
         tx_timeout  <= 1'b0;
      end else begin
         tx_done    <= 1'b0;
         tx_ack_err <= 1'b0;
         tx_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               if (accept) begin
                  // Any device frame in progress is overridden by the inhibit.
                  data_q     <= tx_data;
                  shreg      <= frame_bits(tx_data);
                  cnt        <= '0;
                  retry_cnt  <= '0;
                  ps2_clk_oe <= 1'b1;
                  state      <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               cnt <= sat_inc(cnt);
               if (cnt >= CW'(INHIBIT_CYC - 1)) begin
                  ps2_data_oe <= 1'b1;   // start bit, while clock still held
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               ps2_clk_oe <= 1'b0;
               cnt        <= '0;
               state      <= ST_WAIT_CLK;
            end
            ST_WAIT_CLK: begin
               if (clk_fall) begin
                  // Device has taken the start bit; fall 1 presents d0.
                  ps2_data_oe <= ~shreg[0];
                  shreg       <= {1'b1, shreg[8:1]};
                  bit_cnt     <= 4'd1;
                  fto_cnt     <= '0;
                  state       <= ST_SHIFT;
               end else if (cnt >= CW'(START_CYC - 1)) begin
                  ps2_data_oe <= 1'b0;
                  abort_to    <= 1'b1;
                  state       <= ST_ABORT;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
               fto_cnt <= sat_inc(fto_cnt);
               if (fto_cnt >= CW'(FRAME_CYC - 1)) begin
                  ps2_data_oe <= 1'b0;
                  abort_to    <= 1'b1;
                  state       <= ST_ABORT;
               end else if (state == ST_SHIFT) begin
                  if (clk_fall) begin
                     if (bit_cnt == 4'd9) begin
                        ps2_data_oe <= 1'b0;   // fall 10: stop bit = released line
                        state       <= ST_ACK;
                     end else begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b1, shreg[8:1]};
                        bit_cnt     <= bit_cnt + 4'd1;
                     end
                  end
               end else if (state == ST_ACK) begin
                  if (clk_fall) begin
                     if (!data_s) begin
                        state <= ST_WAIT_IDLE;
                     end else begin
                        abort_to <= 1'b0;
                        state    <= ST_ABORT;
                     end
                  end
               end else begin
                  if (clk_s && data_s) begin
                     tx_done <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_ABORT: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               if (retry_cnt != RW'(RETRIES)) begin
                  // Retry silently: busy stays high, no error pulse yet.
                  retry_cnt  <= retry_cnt + 1'b1;
                  shreg      <= frame_bits(data_q);
                  cnt        <= '0;
                  ps2_clk_oe <= 1'b1;
                  state      <= ST_INHIBIT;
               end else begin
                  if (abort_to) tx_timeout <= 1'b1;
                  else          tx_ack_err <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a device BFM that clocks
// at 12.5 kHz and samples data on its rising clock edges. The DUT runs with a
// 1 MHz clock parameter so the inhibit is 100 cycles, the start timeout 15000
// cycles and the frame timeout 2000 cycles.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int INH        = 100;     // 100 us at 1 MHz
   localparam int START      = 15000;   // 15 ms at 1 MHz
   localparam int HALF       = 40;      // half of an 80 us device clock period
   localparam int RTS_BUDGET = 4 * INH;
`ifdef PS2_TX_RETRY_EN
   localparam int RETRIES = 2;
`else
   localparam int RETRIES = 0;
`endif
   // Release to timeout pulse: START cycles waiting + ABORT, plus for each retry
   // an abort, inhibit, request and another full wait.
   localparam int TMO_EXP = START + 1 + RETRIES * (INH + START + 2);

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic       busy, tx_done, tx_ack_err, tx_timeout;
   tx_state_e  dbg_state;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int checks = 0;
   int errors = 0;

   // Open-drain lines with pull-ups.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_FREQ_HZ (CLK_HZ),
      .INHIBIT_US  (100),
      .START_TO_US (15000),
      .FRAME_TO_US (2000),
      .MAX_RETRY   (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .tx_done     (tx_done),
      .tx_ack_err  (tx_ack_err),
      .tx_timeout  (tx_timeout),
      .dbg_state   (dbg_state)
   );

   // Pulse counters and inhibit measurement.
   int   done_cnt = 0, ackerr_cnt = 0, tmo_cnt = 0;
   int   clk_oe_run = 0, last_run = 0;
   logic data_oe_in_inh = 1'b0, data_oe_at_rel = 1'b0, lines_at_done = 1'b0;

   always @(negedge clk) begin
      if (tx_done) begin
         done_cnt++;
         lines_at_done = ps2_clk_in & ps2_data_in;
      end
      if (tx_ack_err) ackerr_cnt++;
      if (tx_timeout) tmo_cnt++;
      if (ps2_clk_oe) begin
         clk_oe_run++;
         data_oe_in_inh = ps2_data_oe;
      end else if (clk_oe_run != 0) begin
         last_run       = clk_oe_run;
         data_oe_at_rel = data_oe_in_inh;
         clk_oe_run     = 0;
      end
   end

   initial begin
      #(90_000 * 10);
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      check("tx_ready_before_send", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge clk);
      tx_valid = 1'b0;
      check("busy_after_accept", busy, 1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_within_budget", 32'(n < budget), 1);
      repeat (2) @(negedge clk);
   endtask

   // Device side of one frame: wait for request-to-send, then generate n_falls
   // clock pulses, sampling data at each rising edge. With n_falls = 11 the
   // device acknowledges (data low across fall 11) when ack = 1.
   task automatic device_frame(input bit ack, input int n_falls,
                               output logic [7:0] d, output logic par,
                               output logic stp, output logic start);
      int waited;
      d = 8'h00; par = 1'b0; stp = 1'b0; start = 1'b1;
      waited = 0;
      while (!(ps2_clk_in && !ps2_data_in) && waited < RTS_BUDGET) begin
         @(negedge clk);
         waited++;
      end
      check("rts_within_budget", 32'(waited < RTS_BUDGET), 1);
      if (waited >= RTS_BUDGET) return;
      repeat (HALF) @(negedge clk);
      start = ps2_data_in;
      for (int i = 1; i <= n_falls; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i <= 8)       d[i-1] = ps2_data_in;
         else if (i == 9)  par    = ps2_data_in;
         else if (i == 10) stp    = ps2_data_in;
         if (i == 10 && ack) begin
            repeat (HALF / 2) @(negedge clk);
            dev_data_low = 1'b1;
            repeat (HALF / 2) @(negedge clk);
         end else if (i < n_falls) begin
            repeat (HALF) @(negedge clk);
         end
      end
      if (n_falls == 11) begin
         repeat (4) @(negedge clk);
         dev_data_low = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] got;
      logic       par, stp, start;
      int         d0, a0, t0, n, t;
      logic       ready_seen;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_clk_oe", ps2_clk_oe, 0);
      check("reset_data_oe", ps2_data_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_tx_ready", tx_ready, 0);
      check("reset_tx_done", tx_done, 0);
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("ready_after_reset", tx_ready, 1);

      // 1: set-LEDs command, acknowledged
      d0 = done_cnt; a0 = ackerr_cnt;
      send_cmd(CMD_SET_LEDS);
      device_frame(1'b1, 11, got, par, stp, start);
      wait_idle(500);
      check("t1_clk_inhibit_min", 32'(last_run >= INH), 1);
      check("t1_clk_inhibit_max", 32'(last_run <= INH + 2), 1);
      check("t1_data_low_before_release", data_oe_at_rel, 1);
      check("t1_start_bit", start, 0);
      check("t1_data", got, 8'hED);
      check("t1_parity", par, 1);
      check("t1_stop", stp, 1);
      check("t1_done_once", done_cnt - d0, 1);
      check("t1_no_ack_err", ackerr_cnt - a0, 0);
      check("t1_lines_idle_at_done", lines_at_done, 1);
      check("t1_ready_again", tx_ready, 1);

      // 2: parity of 0x01 and 0xFF
      send_cmd(8'h01);
      device_frame(1'b1, 11, got, par, stp, start);
      wait_idle(500);
      check("t2a_data", got, 8'h01);
      check("t2a_parity", par, 0);
      check("t2a_stop", stp, 1);
      send_cmd(CMD_RESET);
      device_frame(1'b1, 11, got, par, stp, start);
      wait_idle(500);
      check("t2b_data", got, 8'hFF);
      check("t2b_parity", par, 1);

      // 3: no acknowledge at fall 11 (every attempt when retries are enabled)
      d0 = done_cnt; a0 = ackerr_cnt; t0 = tmo_cnt;
      send_cmd(8'hF4);
      for (int a = 0; a <= RETRIES; a++) begin
         device_frame(1'b0, 11, got, par, stp, start);
         check("t3_data", got, 8'hF4);
      end
      wait_idle(500);
      check("t3_ack_err_once", ackerr_cnt - a0, 1);
      check("t3_no_done", done_cnt - d0, 0);
      check("t3_no_timeout", tmo_cnt - t0, 0);
      check("t3_ready_again", tx_ready, 1);

      // 4: device never clocks
      d0 = done_cnt; a0 = ackerr_cnt; t0 = tmo_cnt;
      send_cmd(CMD_RESET);
      n = 0;
      while (ps2_clk_oe && n < RTS_BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("t4_clk_released", ps2_clk_oe, 0);
      t = 0;
      while (!tx_timeout && t < TMO_EXP + 50) begin
         @(negedge clk);
         t++;
      end
      check("t4_timeout_latency_min", 32'(t >= TMO_EXP - 2), 1);
      check("t4_timeout_latency_max", 32'(t <= TMO_EXP + 2), 1);
      check("t4_clk_oe_released", ps2_clk_oe, 0);
      check("t4_data_oe_released", ps2_data_oe, 0);
      repeat (2) @(negedge clk);
      check("t4_timeout_once", tmo_cnt - t0, 1);
      check("t4_no_done", done_cnt - d0, 0);
      check("t4_no_ack_err", ackerr_cnt - a0, 0);

      // 5: reset while the host is driving d4 of 0xEE (d4 = 0 -> data pulled low)
      send_cmd(CMD_ECHO);
      device_frame(1'b1, 5, got, par, stp, start);
      check("t5_low_nibble", 32'(got[3:0]), 4'hE);
      check("t5_d4_driven", ps2_data_oe, 1);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("t5_clk_oe_in_reset", ps2_clk_oe, 0);
      check("t5_data_oe_in_reset", ps2_data_oe, 0);
      check("t5_busy_in_reset", busy, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      ready_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (tx_ready) ready_seen = 1'b1;
      end
      check("t5_ready_within_3", ready_seen, 1);

      // 6: request during busy is ignored; with retries, first attempt nacked
      d0 = done_cnt; a0 = ackerr_cnt;
      send_cmd(CMD_ECHO);
      repeat (10) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      repeat (5) @(negedge clk);
      tx_valid = 1'b0;
`ifdef PS2_TX_RETRY_EN
      device_frame(1'b0, 11, got, par, stp, start);
      check("t6_busy_between_attempts", busy, 1);
`endif
      device_frame(1'b1, 11, got, par, stp, start);
      wait_idle(500);
      check("t6_data", got, 8'hEE);
      check("t6_parity", par, 1);
      check("t6_done_once", done_cnt - d0, 1);
      check("t6_no_ack_err", ackerr_cnt - a0, 0);
      repeat (100) @(negedge clk);
      check("t6_no_queued_cmd", busy, 0);
      check("t6_clk_idle", ps2_clk_oe, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
